// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the fetch / load-store bus arbiter: the state encoding
// and the default bus width.
package bus_arbiter_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int STATE_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_LS_WAIT = 2'd2
    } arb_state_e;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch requester, load/store requester and single-port memory
// signals; the arbiter uses the master view, the environment the slave view.
interface bus_arbiter_if #(
    parameter int XLEN = bus_arbiter_pkg::DEFAULT_XLEN
);

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            ls_req;
    logic            ls_we;
    logic [3:0]      ls_byte_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;

    logic            bus_req;
    logic            bus_we;
    logic [3:0]      bus_byte_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;

    logic            arb_busy;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_byte_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output bus_req, bus_we, bus_byte_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output arb_busy
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_byte_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  bus_req, bus_we, bus_byte_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  arb_busy
    );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter.sv
// Two-requester arbiter (fetch vs load/store) in front of a single-port memory
// with one outstanding transaction and a starvation cap on back-to-back LSU wins.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e       r_state, w_next_state;
    logic [CNT_W-1:0] r_starve_cnt, w_next_starve;
    logic             r_drop, w_next_drop;

    logic            w_if_req_eff, w_starved;
    logic            w_sel_if, w_sel_ls, w_accept_if, w_accept_ls;
    logic            w_bus_we;
    logic [3:0]      w_bus_byte_we;
    logic [XLEN-1:0] w_bus_addr, w_bus_wdata;

    // State, starvation counter and drop flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_starve;
            r_drop       <= w_next_drop;
        end
    end

    // Requester selection: LS wins ties until the fetch side has been starved
    always_comb begin
        w_if_req_eff = bus.if_req & ~bus.if_flush;
        w_starved    = (r_starve_cnt == CNT_MAX);
        w_sel_if     = 1'b0;
        w_sel_ls     = 1'b0;
        if (r_state == ST_IDLE) begin
            w_sel_if = w_if_req_eff & (~bus.ls_req | w_starved);
            w_sel_ls = bus.ls_req & ~w_sel_if;
        end else begin
            w_sel_if = 1'b0;
            w_sel_ls = 1'b0;
        end
        w_accept_if = w_sel_if & bus.bus_gnt;
        w_accept_ls = w_sel_ls & bus.bus_gnt;
    end

    // Next-state, starvation counter and drop flag update
    always_comb begin
        w_next_state  = r_state;
        w_next_starve = r_starve_cnt;
        w_next_drop   = r_drop;
        case (r_state)
            ST_IDLE: begin
                w_next_drop = 1'b0;
                if (w_accept_if) begin
                    w_next_state  = ST_IF_WAIT;
                    w_next_starve = '0;
                end else if (!w_if_req_eff) begin
                    w_next_starve = '0;
                    w_next_state  = w_accept_ls ? ST_LS_WAIT : ST_IDLE;
                end else if (w_accept_ls) begin
                    w_next_state  = ST_LS_WAIT;
                    w_next_starve = w_starved ? r_starve_cnt : (r_starve_cnt + CNT_ONE);
                end else begin
                    w_next_starve = r_starve_cnt;
                end
            end
            ST_IF_WAIT: begin
                if (bus.bus_rvalid) begin
                    w_next_state = ST_IDLE;
                    w_next_drop  = 1'b0;
                end else if (bus.if_flush) begin
                    w_next_drop = 1'b1;
                end else begin
                    w_next_drop = r_drop;
                end
            end
            ST_LS_WAIT: begin
                if (bus.bus_rvalid) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_LS_WAIT;
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_next_starve = '0;
                w_next_drop   = 1'b0;
            end
        endcase
    end

    // Payload mux from the selected requester; fetches are always reads
    always_comb begin
        w_bus_we      = 1'b0;
        w_bus_byte_we = 4'b0000;
        w_bus_addr    = '0;
        w_bus_wdata   = '0;
        if (w_sel_ls) begin
            w_bus_we      = bus.ls_we;
            w_bus_byte_we = bus.ls_byte_we;
            w_bus_addr    = bus.ls_addr;
            w_bus_wdata   = bus.ls_wdata;
        end else if (w_sel_if) begin
            w_bus_addr = bus.if_addr;
        end else begin
            w_bus_addr = '0;
        end
    end

    // Output drive; every output is held at zero while reset is asserted
    always_comb begin
        bus.bus_req     = 1'b0;
        bus.bus_we      = 1'b0;
        bus.bus_byte_we = 4'b0000;
        bus.bus_addr    = '0;
        bus.bus_wdata   = '0;
        bus.if_gnt      = 1'b0;
        bus.ls_gnt      = 1'b0;
        bus.if_rvalid   = 1'b0;
        bus.ls_rvalid   = 1'b0;
        bus.if_rdata    = '0;
        bus.ls_rdata    = '0;
        bus.arb_busy    = 1'b0;
        if (rst_n) begin
            bus.bus_req     = (r_state == ST_IDLE) & (w_if_req_eff | bus.ls_req);
            bus.bus_we      = w_bus_we;
            bus.bus_byte_we = w_bus_byte_we;
            bus.bus_addr    = w_bus_addr;
            bus.bus_wdata   = w_bus_wdata;
            bus.if_gnt      = w_accept_if;
            bus.ls_gnt      = w_accept_ls;
            // A flush arriving in the response cycle still kills the response
            bus.if_rvalid   = (r_state == ST_IF_WAIT) & bus.bus_rvalid & ~r_drop & ~bus.if_flush;
            bus.ls_rvalid   = (r_state == ST_LS_WAIT) & bus.bus_rvalid;
            bus.if_rdata    = bus.bus_rdata;
            bus.ls_rdata    = bus.bus_rdata;
            bus.arb_busy    = (r_state != ST_IDLE);
        end else begin
            bus.bus_req = 1'b0;
        end
    end

endmodule : bus_arbiter
